// File: rtl/operand_fetch_pkg.sv
// Shared widths, decode/writeback/output bundle types and helpers for the operand fetch stage.
package operand_fetch_pkg;

    localparam int OF_XLEN   = 32;
    localparam int OF_NREG   = 32;
    localparam int OF_AW     = $clog2(OF_NREG);
    localparam int OF_CTRL_W = 64;

    typedef struct packed {
        logic [OF_AW-1:0]     rs1;
        logic                 rs1_en;
        logic [OF_AW-1:0]     rs2;
        logic                 rs2_en;
        logic [OF_AW-1:0]     rd;
        logic                 rd_en;
        logic [OF_CTRL_W-1:0] ctrl;
    } of_in_type;

    typedef struct packed {
        logic [OF_XLEN-1:0]   op1;
        logic [OF_XLEN-1:0]   op2;
        logic [OF_AW-1:0]     rd;
        logic                 rd_en;
        logic [OF_CTRL_W-1:0] ctrl;
    } of_out_type;

    typedef struct packed {
        logic               valid;
        logic [OF_AW-1:0]   addr;
        logic [OF_XLEN-1:0] data;
    } of_wb_type;

    // x0 is hardwired, so a writeback aimed at it never counts as a hit.
    function automatic logic of_wb_hit(input of_wb_type wb, input logic [OF_AW-1:0] idx);
        return wb.valid && (wb.addr == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register pending scoreboard: one set port (issue), one clear port (writeback),
// and enable-qualified pending lookups for two sources and one destination.
module operand_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter  int NREG = OF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic          rs1_en,
    input  logic [AW-1:0] rs2_addr,
    input  logic          rs2_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_en,
    output logic          rs1_pend,
    output logic          rs2_pend,
    output logic          rd_pend
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    function automatic logic lookup(input logic [NREG-1:0] vec,
                                    input logic [AW-1:0]   idx,
                                    input logic            en);
        return en && (idx != '0) && vec[idx];
    endfunction

    // Clear applied before set so a same-cycle issue to the retiring index keeps it pending.
    always_comb begin
        pend_nxt = pend;
        if (clr_en) begin
            pend_nxt[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            pend_nxt[set_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign rs1_pend = lookup(pend, rs1_addr, rs1_en);
    assign rs2_pend = lookup(pend, rs2_addr, rs2_en);
    assign rd_pend  = lookup(pend, rd_addr,  rd_en);

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch stage with pending scoreboard and one registered output bundle.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data and let it satisfy hazards.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter  int XLEN = OF_XLEN,
    parameter  int NREG = OF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic            in_rs1_en,
    input  logic [AW-1:0]   in_rs2,
    input  logic            in_rs2_en,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rd_en,
    input  logic [63:0]     in_ctrl,
    output logic [AW-1:0]   rf_raddr1,
    output logic            rf_rden1,
    output logic [AW-1:0]   rf_raddr2,
    output logic            rf_rden2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic            out_rd_en,
    output logic [63:0]     out_ctrl
);

    of_in_type  in_p0;
    of_wb_type  wb_p0;
    of_out_type bundle_p0;
    of_out_type bundle_p1;
    logic       vld_p1;

    logic hit_rs1;
    logic hit_rs2;
    logic hit_rd;
    logic rs1_pend;
    logic rs2_pend;
    logic rd_pend;
    logic raw_hazard;
    logic waw_hazard;
    logic accept;

    // Disabled sources and x0 read as zero; a forwarded writeback overrides the regfile.
    function automatic logic [OF_XLEN-1:0] sel_operand(input logic               en,
                                                       input logic [OF_AW-1:0]   idx,
                                                       input logic               hit,
                                                       input logic [OF_XLEN-1:0] wb_val,
                                                       input logic [OF_XLEN-1:0] rf_val);
        if (!en || (idx == '0)) begin
            return '0;
        end else if (hit) begin
            return wb_val;
        end
        return rf_val;
    endfunction

    // ---- stage p0: decode fields, regfile read, hazard check ----
    assign in_p0 = '{rs1: in_rs1, rs1_en: in_rs1_en,
                     rs2: in_rs2, rs2_en: in_rs2_en,
                     rd:  in_rd,  rd_en:  in_rd_en,
                     ctrl: in_ctrl};
    assign wb_p0 = '{valid: wb_valid, addr: wb_addr, data: wb_data};

    assign rf_raddr1 = in_p0.rs1;
    assign rf_raddr2 = in_p0.rs2;
    assign rf_rden1  = in_valid & in_p0.rs1_en;
    assign rf_rden2  = in_valid & in_p0.rs2_en;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign hit_rs1 = of_wb_hit(wb_p0, in_p0.rs1);
    assign hit_rs2 = of_wb_hit(wb_p0, in_p0.rs2);
    assign hit_rd  = of_wb_hit(wb_p0, in_p0.rd);
`else
    // Without forwarding a retiring writeback cannot help this cycle; the stall
    // lasts one more cycle and the operand then comes from the updated regfile.
    assign hit_rs1 = 1'b0;
    assign hit_rs2 = 1'b0;
    assign hit_rd  = 1'b0;
`endif

    operand_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept & in_p0.rd_en),
        .set_addr (in_p0.rd),
        .clr_en   (wb_p0.valid),
        .clr_addr (wb_p0.addr),
        .rs1_addr (in_p0.rs1),
        .rs1_en   (in_p0.rs1_en),
        .rs2_addr (in_p0.rs2),
        .rs2_en   (in_p0.rs2_en),
        .rd_addr  (in_p0.rd),
        .rd_en    (in_p0.rd_en),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend)
    );

    assign raw_hazard = (rs1_pend & ~hit_rs1) | (rs2_pend & ~hit_rs2);
    assign waw_hazard = rd_pend & ~hit_rd;

    assign in_ready = ~(raw_hazard | waw_hazard) & (~vld_p1 | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        bundle_p0       = '0;
        bundle_p0.op1   = sel_operand(in_p0.rs1_en, in_p0.rs1, hit_rs1, wb_p0.data, rf_rdata1);
        bundle_p0.op2   = sel_operand(in_p0.rs2_en, in_p0.rs2, hit_rs2, wb_p0.data, rf_rdata2);
        bundle_p0.rd    = in_p0.rd;
        bundle_p0.rd_en = in_p0.rd_en;
        bundle_p0.ctrl  = in_p0.ctrl;
    end

    // ---- stage p1: registered bundle presented to execute ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            bundle_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            bundle_p1 <= bundle_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_op1   = bundle_p1.op1;
    assign out_op2   = bundle_p1.op2;
    assign out_rd    = bundle_p1.rd;
    assign out_rd_en = bundle_p1.rd_en;
    assign out_ctrl  = bundle_p1.ctrl;

endmodule
